// File: rtl/pr_timer.sv
// pr_timer: programmable countdown timer peripheral on the Pr bus.
// Registers: CTRL (EN, MODE, IM), PRESET, COUNT (read-only) and, when the
// TIMER_PRESCALE_EN macro is defined, a PSC prescale register at offset 3.
// Without the macro the counter steps every clock and offset 3 reads zero.
module pr_timer
`ifdef TIMER_PRESCALE_EN
#(
   parameter int PRESCALE_W = 8
)
`endif
(
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic [1:0]  addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      CNT  = 2'd2,
      INT  = 2'd3
   } state_t;

   state_t      state;
   state_t      state_next;

   logic        ctrl_en;
   logic [1:0]  ctrl_mode;
   logic        ctrl_im;
   logic [31:0] preset;
   logic [31:0] count;
   logic        irq_flag;

   logic        wr_ctrl;
   logic        wr_preset;
   logic        wr_stop;
   logic        tick;
   logic        load_count;
   logic        dec_count;
   logic        term_hit;
   logic        auto_clr;
   logic        oneshot_done;

   assign wr_ctrl   = we && (addr == 2'd0);
   assign wr_preset = we && (addr == 2'd1);
   // A PRESET write, or a CTRL write that clears EN, freezes COUNT on that edge.
   assign wr_stop   = wr_preset || (wr_ctrl && !wdata[0]);

`ifdef TIMER_PRESCALE_EN
   logic                  wr_psc;
   logic [PRESCALE_W-1:0] psc;
   logic [PRESCALE_W-1:0] divider;

   assign wr_psc = we && (addr == 2'd3);
   assign tick   = (divider == psc);

   // Prescale register and divider; the divider restarts on LOAD and on any control write.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         psc     <= '0;
         divider <= '0;
      end else begin
         if (wr_psc)
            psc <= wdata[PRESCALE_W-1:0];
         if (wr_ctrl || wr_preset || load_count)
            divider <= '0;
         else if ((state == CNT) && ctrl_en)
            divider <= tick ? '0 : divider + {{(PRESCALE_W-1){1'b0}}, 1'b1};
      end
   end
`else
   assign tick = 1'b1;
`endif

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Next-state logic and per-state actions; bus writes override the normal flow.
   always_comb begin
      state_next   = state;
      load_count   = 1'b0;
      dec_count    = 1'b0;
      term_hit     = 1'b0;
      auto_clr     = 1'b0;
      oneshot_done = 1'b0;
      case (state)
         IDLE: begin
            if (ctrl_en)
               state_next = LOAD;
         end
         LOAD: begin
            load_count = 1'b1;
            state_next = CNT;
         end
         CNT: begin
            if (!ctrl_en) begin
               state_next = IDLE;
            end else if (tick) begin
               if (count > 32'd1) begin
                  dec_count = 1'b1;
               end else begin
                  term_hit   = 1'b1;
                  state_next = INT;
               end
            end
         end
         INT: begin
            if (ctrl_mode == 2'b01) begin
               auto_clr   = 1'b1;
               state_next = LOAD;
            end else begin
               oneshot_done = 1'b1;
               state_next   = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
      if (wr_preset) begin
         state_next = IDLE;
      end else if (wr_ctrl) begin
         if (!wdata[0])
            state_next = IDLE;
         else if (term_hit)
            state_next = CNT;
      end
   end

   // CTRL register; a finished one-shot clears EN unless software writes on that edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ctrl_en   <= 1'b0;
         ctrl_mode <= 2'b00;
         ctrl_im   <= 1'b0;
      end else if (wr_ctrl) begin
         ctrl_en   <= wdata[0];
         ctrl_mode <= wdata[2:1];
         ctrl_im   <= wdata[3];
      end else if (oneshot_done && !wr_preset) begin
         ctrl_en   <= 1'b0;
      end
   end

   // PRESET register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         preset <= '0;
      else if (wr_preset)
         preset <= wdata;
   end

   // COUNT register: load, decrement, or clamp to zero at terminal count.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         count <= '0;
      else if (!wr_stop) begin
         if (load_count)
            count <= preset;
         else if (dec_count)
            count <= count - 32'd1;
         else if (term_hit)
            count <= '0;
      end
   end

   // Interrupt flag: any CTRL/PRESET write wins over terminal count.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         irq_flag <= 1'b0;
      else if (wr_ctrl || wr_preset)
         irq_flag <= 1'b0;
      else if (term_hit)
         irq_flag <= 1'b1;
      else if (auto_clr)
         irq_flag <= 1'b0;
   end

   assign irq = irq_flag && ctrl_im;

   // Read mux, purely combinational on addr.
   always_comb begin
      rdata = '0;
      case (addr)
         2'd0: rdata = {28'd0, ctrl_im, ctrl_mode, ctrl_en};
         2'd1: rdata = preset;
         2'd2: rdata = count;
         default: begin
`ifdef TIMER_PRESCALE_EN
            rdata[PRESCALE_W-1:0] = psc;
`else
            rdata = '0;
`endif
         end
      endcase
   end

endmodule

// File: tb/tb_pr_timer.sv
// tb_pr_timer: directed bench for pr_timer. Stimulus pushes expected rdata/irq
// into a scoreboard queue; a monitor pops and compares on each falling edge
// (or on an explicit strobe while the clock is stopped).
module tb_pr_timer;

   logic        clk = 1'b0;
   logic        clk_en = 1'b1;
   logic        reset;
   logic        we;
   logic [1:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        irq;

   logic        obs_valid = 1'b0;
   logic        async_sample = 1'b0;
   int          checks = 0;
   int          errors = 0;

   typedef struct {
      logic [31:0] rd;
      logic        irq;
      string       name;
   } exp_t;

   exp_t sb_q[$];

   pr_timer dut (
      .clk   (clk),
      .reset (reset),
      .we    (we),
      .addr  (addr),
      .wdata (wdata),
      .rdata (rdata),
      .irq   (irq)
   );

   // Free-running clock that can be frozen for the asynchronous reset check.
   always #5 if (clk_en) clk = ~clk;

   // Safety net so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input exp_t e);
      checks++;
      if ((rdata !== e.rd) || (irq !== e.irq)) begin
         errors++;
         $display("[TB] FAIL %s: got rdata=0x%08h irq=%0b, expected rdata=0x%08h irq=%0b",
                  e.name, rdata, irq, e.rd, e.irq);
      end
   endtask

   // Monitor: compares whatever the DUT presents against the oldest expectation.
   initial begin
      forever begin
         @(negedge clk or posedge async_sample);
         if (obs_valid) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL scoreboard_underflow: got rdata=0x%08h irq=%0b, expected a queued entry",
                        rdata, irq);
            end else begin
               checkOutput(sb_q.pop_front());
            end
         end
      end
   end

   // One bus cycle: drive inputs, optionally queue the expected response, advance past the edge.
   task automatic applyStimulus(input logic w, input logic [1:0] a, input logic [31:0] d,
                                input logic chk, input logic [31:0] exp_rd, input logic exp_irq,
                                input string nm);
      exp_t e;
      we        = w;
      addr      = a;
      wdata     = d;
      obs_valid = chk;
      if (chk) begin
         e.rd   = exp_rd;
         e.irq  = exp_irq;
         e.name = nm;
         sb_q.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic read_check(input logic [1:0] a, input logic [31:0] exp_rd, input logic exp_irq,
                             input string nm);
      applyStimulus(1'b0, a, 32'd0, 1'b1, exp_rd, exp_irq, nm);
   endtask

   task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
      applyStimulus(1'b1, a, d, 1'b0, 32'd0, 1'b0, "");
   endtask

   // Compare while the clock is frozen, using the explicit monitor strobe.
   task automatic async_check(input logic [1:0] a, input logic [31:0] exp_rd, input logic exp_irq,
                              input string nm);
      exp_t e;
      we   = 1'b0;
      addr = a;
      #1;
      e.rd   = exp_rd;
      e.irq  = exp_irq;
      e.name = nm;
      sb_q.push_back(e);
      obs_valid    = 1'b1;
      async_sample = 1'b1;
      #1;
      async_sample = 1'b0;
      obs_valid    = 1'b0;
      #1;
   endtask

   initial begin
      reset = 1'b0;
      we    = 1'b0;
      addr  = 2'd0;
      wdata = 32'd0;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b1;
      $display("[TB] reset released");

      // Reset state.
      read_check(2'd0, 32'd0, 1'b0, "rst_ctrl");
      read_check(2'd1, 32'd0, 1'b0, "rst_preset");
      read_check(2'd2, 32'd0, 1'b0, "rst_count");
      read_check(2'd3, 32'd0, 1'b0, "rst_psc");

      // One-shot, PRESET=3: COUNT 3,2,1,0 from t2, irq level from t5.
      write_reg(2'd1, 32'd3);
      write_reg(2'd0, 32'h9);
      read_check(2'd2, 32'd0, 1'b0, "os_idle");
      read_check(2'd2, 32'd0, 1'b0, "os_load");
      read_check(2'd2, 32'd3, 1'b0, "os_cnt3");
      read_check(2'd2, 32'd2, 1'b0, "os_cnt2");
      read_check(2'd2, 32'd1, 1'b0, "os_cnt1");
      read_check(2'd2, 32'd0, 1'b1, "os_cnt0_irq");
      read_check(2'd0, 32'h8, 1'b1, "os_ctrl_en_cleared");
      read_check(2'd0, 32'h8, 1'b1, "os_irq_held");
      write_reg(2'd0, 32'h8);
      read_check(2'd0, 32'h8, 1'b0, "os_irq_cleared");

      // PRESET=0 behaves like PRESET=1.
      write_reg(2'd1, 32'd0);
      write_reg(2'd0, 32'h9);
      read_check(2'd2, 32'd0, 1'b0, "p0_idle");
      read_check(2'd2, 32'd0, 1'b0, "p0_load");
      read_check(2'd2, 32'd0, 1'b0, "p0_cnt");
      read_check(2'd2, 32'd0, 1'b1, "p0_irq");
      read_check(2'd0, 32'h8, 1'b1, "p0_ctrl");
      write_reg(2'd0, 32'h8);

      // Masked one-shot: counts down but irq never rises.
      write_reg(2'd1, 32'd3);
      write_reg(2'd0, 32'h1);
      read_check(2'd2, 32'd0, 1'b0, "mask_idle");
      read_check(2'd2, 32'd0, 1'b0, "mask_load");
      read_check(2'd2, 32'd3, 1'b0, "mask_cnt3");
      read_check(2'd2, 32'd2, 1'b0, "mask_cnt2");
      read_check(2'd2, 32'd1, 1'b0, "mask_cnt1");
      read_check(2'd2, 32'd0, 1'b0, "mask_cnt0");
      read_check(2'd0, 32'h0, 1'b0, "mask_ctrl");
      write_reg(2'd0, 32'h8);
      read_check(2'd0, 32'h8, 1'b0, "mask_flag_cleared");
      read_check(2'd2, 32'd0, 1'b0, "mask_count_zero");

      // Auto-reload, PRESET=2: period of 4 cycles, one-cycle irq pulse.
      write_reg(2'd1, 32'd2);
      write_reg(2'd0, 32'hB);
      read_check(2'd2, 32'd0, 1'b0, "ar_idle");
      read_check(2'd2, 32'd0, 1'b0, "ar_load");
      for (int p = 0; p < 3; p++) begin
         read_check(2'd2, 32'd2, 1'b0, $sformatf("ar_p%0d_cnt2", p));
         read_check(2'd2, 32'd1, 1'b0, $sformatf("ar_p%0d_cnt1", p));
         read_check(2'd2, 32'd0, 1'b1, $sformatf("ar_p%0d_irq", p));
         read_check(2'd2, 32'd0, 1'b0, $sformatf("ar_p%0d_reload", p));
      end
      applyStimulus(1'b1, 2'd0, 32'h0, 1'b1, 32'hB, 1'b0, "ar_stop_write");
      read_check(2'd2, 32'd2, 1'b0, "ar_count_held");
      read_check(2'd2, 32'd2, 1'b0, "ar_count_still_held");

      // Mid-count PRESET write reloads the new value through LOAD.
      write_reg(2'd1, 32'd10);
      write_reg(2'd0, 32'h9);
      read_check(2'd2, 32'd2, 1'b0, "mid_idle");
      read_check(2'd2, 32'd2, 1'b0, "mid_load");
      read_check(2'd2, 32'd10, 1'b0, "mid_cnt10");
      read_check(2'd2, 32'd9, 1'b0, "mid_cnt9");
      read_check(2'd2, 32'd8, 1'b0, "mid_cnt8");
      read_check(2'd2, 32'd7, 1'b0, "mid_cnt7");
      read_check(2'd2, 32'd6, 1'b0, "mid_cnt6");
      applyStimulus(1'b1, 2'd1, 32'd2, 1'b1, 32'd10, 1'b0, "mid_write_at5");
      read_check(2'd2, 32'd5, 1'b0, "mid_forced_idle");
      read_check(2'd2, 32'd5, 1'b0, "mid_reload");
      read_check(2'd2, 32'd2, 1'b0, "mid_new2");
      read_check(2'd2, 32'd1, 1'b0, "mid_new1");
      read_check(2'd2, 32'd0, 1'b1, "mid_irq");
      read_check(2'd0, 32'h8, 1'b1, "mid_ctrl");
      write_reg(2'd0, 32'h8);
      read_check(2'd1, 32'd2, 1'b0, "mid_preset");

`ifdef TIMER_PRESCALE_EN
      // Prescale 3: each COUNT value held 4 cycles.
      write_reg(2'd3, 32'd3);
      read_check(2'd3, 32'd3, 1'b0, "psc_readback");
      write_reg(2'd1, 32'd2);
      write_reg(2'd0, 32'h9);
      read_check(2'd2, 32'd0, 1'b0, "psc_idle");
      read_check(2'd2, 32'd0, 1'b0, "psc_load");
      for (int i = 0; i < 4; i++)
         read_check(2'd2, 32'd2, 1'b0, $sformatf("psc_cnt2_%0d", i));
      for (int i = 0; i < 4; i++)
         read_check(2'd2, 32'd1, 1'b0, $sformatf("psc_cnt1_%0d", i));
      read_check(2'd2, 32'd0, 1'b1, "psc_irq");
      write_reg(2'd0, 32'h8);
`else
      // Offset 3 is unimplemented: writes vanish, reads are zero.
      write_reg(2'd3, 32'hFF);
      read_check(2'd3, 32'd0, 1'b0, "off3_zero");
`endif

      // Asynchronous reset while running with the clock frozen.
      write_reg(2'd1, 32'd5);
      write_reg(2'd0, 32'hB);
      for (int i = 0; i < 4; i++)
         applyStimulus(1'b0, 2'd2, 32'd0, 1'b0, 32'd0, 1'b0, "");
      obs_valid = 1'b0;
      clk_en    = 1'b0;
      #2;
      reset = 1'b0;
      async_check(2'd0, 32'd0, 1'b0, "arst_ctrl");
      async_check(2'd1, 32'd0, 1'b0, "arst_preset");
      async_check(2'd2, 32'd0, 1'b0, "arst_count");
      async_check(2'd3, 32'd0, 1'b0, "arst_psc");
      reset  = 1'b1;
      #2;
      clk_en = 1'b1;
      @(posedge clk);
      #1;
      read_check(2'd0, 32'd0, 1'b0, "post_rst_ctrl");
      read_check(2'd2, 32'd0, 1'b0, "post_rst_count");

      we        = 1'b0;
      obs_valid = 1'b0;
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending entries, expected 0", sb_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
